harris_pixel_source: RTL and testbench
======================================

Name: harris_pixel_source

Overview:
- Synthesizable raster pixel streamer that drives the harrisDetector input interface (pixel, pixel_valid) from a byte-wide frame memory.
- Used in place of the simulation file reader for on-chip frame playback.
- Fetches one full frame in row-major order on a start pulse.
- Emits frame and line markers and honours an upstream stall.
- Inserts programmable horizontal blanking between rows.

Parameters:
- IMG_W, 64, pixels per row (>=2)
- IMG_H, 64, rows per frame (>=1)
- ADDR_W, 12, memory address width; IMG_W*IMG_H <= 2**ADDR_W
- HBLANK, 2, idle cycles inserted after each row's last fetch (0 allowed)

Ports:
- clk, input, 1, system clock, all logic on rising edge
- reset, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle request to stream one frame; ignored while busy=1
- stall, input, 1, when 1 no new memory read is issued
- mem_rd, output, 1, memory read strobe
- mem_addr, output, ADDR_W, read address, row*IMG_W+col
- mem_rdata, input, 8, read data, valid exactly 1 cycle after mem_rd
- pixel, output, 8, pixel to detector
- pixel_valid, output, 1, pixel qualifier
- sof, output, 1, high with first pixel of frame
- eol, output, 1, high with last pixel of each row
- eof, output, 1, high with last pixel of frame
- busy, output, 1, high from accepted start until done
- done, output, 1, one-cycle pulse the cycle after the eof pixel

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - All outputs 0: mem_rd, mem_addr, pixel, pixel_valid, sof, eol, eof, busy, done.
  - Counters cleared.
  - Assertion mid-frame aborts immediately; in-flight reads are discarded; no done is produced.
- FSM states: IDLE, STREAM, BLANK, DRAIN.
- IDLE -> STREAM on start=1.
  - busy is 1 from the next cycle.
  - col=0, row=0.
- STREAM, each cycle with stall=0:
  - mem_rd=1, mem_addr=row*IMG_W+col.
  - Advance col.
  - At col=IMG_W-1 wrap col to 0 and increment row.
  - After the row's last fetch: go to BLANK if HBLANK>0, else stay in STREAM.
  - After the fetch of (IMG_H-1, IMG_W-1): go to DRAIN.
- STREAM with stall=1: mem_rd=0, counters hold, mem_addr holds.
- BLANK: count HBLANK cycles with mem_rd=0, then return to STREAM.
  - stall has no effect on the blank count.
- DRAIN: wait for outstanding reads to emit, then go to IDLE with a done pulse.
- Pipeline and latency:
  - Read issued in cycle t; mem_rdata captured in cycle t+1; pixel and pixel_valid registered and visible in cycle t+2.
  - Latency from start sample to first pixel_valid is 3 cycles.
  - A read issued before stall rose is always emitted; no pixel is lost or duplicated.
- Markers:
  - sof, eol and eof travel with the pipeline and align exactly with their pixel_valid.
  - Pixels with IMG_W=1 are not supported.
- Output hold: pixel holds its last value when pixel_valid=0.
- busy and done:
  - busy falls in the same cycle done pulses.
  - A start in the done cycle is ignored.
  - A start in the cycle after done is accepted.
- Throughput with HBLANK=0 and no stall: IMG_W*IMG_H consecutive valid cycles.

Decomposition:
- Shared package harris_pkg holds:
  - PIX_W=8
  - FSM state encoding for this block
  - the IMG_W/IMG_H defaults shared with harrisDetector
- One natural sub-module, harris_raster_counter: col/row counter with enable, last_col and last_pixel flags.
- The FSM and the 2-stage marker pipeline stay in the top module.

Test Plan:
- IMG_W=4, IMG_H=2, HBLANK=0, memory holds addr value (rdata=addr):
  - start -> pixel_valid 8 consecutive cycles starting 3 cycles after start.
  - pixels 0..7.
  - sof on 0, eol on 3 and 7, eof on 7.
  - done one cycle after 7.
- Same frame, HBLANK=2 -> exactly 2 pixel_valid=0 cycles between pixel 3 and pixel 4; total span 10 cycles.
- stall=1 for 3 cycles beginning the cycle after the fetch of address 1:
  - pixels still 0..7 in order, no gap-fill duplicates.
  - a 3-cycle hole appears in pixel_valid after pixel 1.
- start pulsed again while busy (mid-frame) -> ignored; exactly one frame and one done.
- reset low in the cycle pixel 2 is valid:
  - all outputs 0 immediately.
  - after release, a new start streams a full frame from pixel 0 with sof.
- Back-to-back: start in the cycle after done -> second frame begins with sof 3 cycles later; pixel values identical to the first frame.

Source files
------------

// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared types and defaults for the harris pixel path
package harris_pkg;

  // Pixel width on the detector interface
  localparam int PIX_W = 8;

  // Frame geometry defaults shared with harrisDetector
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;

  // Pixel source sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_BLANK  = 2'd2,
    ST_DRAIN  = 2'd3
  } src_state_t;

endpackage

// File: rtl/harris_raster_counter.sv
// rtl/harris_raster_counter.sv - row-major col/row counter with linear address
module harris_raster_counter
  import harris_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pixel
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign last_col   = (col == COL_W'(IMG_W - 1));
  assign last_pixel = last_col && (row == ROW_W'(IMG_H - 1));

  // Advance col/row and keep a running address so no multiplier is needed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      if (last_pixel) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (last_col) begin
        col  <= '0;
        row  <= row + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/harris_pixel_source.sv
// rtl/harris_pixel_source.sv - frame memory to harrisDetector raster streamer
module harris_pixel_source
  import harris_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 12,
  parameter int HBLANK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pixel,
  output logic              pixel_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [BW-1:0] BLANK_LAST = (HBLANK > 0) ? BW'(HBLANK - 1) : '0;

  src_state_t        state, state_next;
  logic              cnt_en, cnt_clr;
  logic [ADDR_W-1:0] cnt_addr;
  logic              last_col, last_pixel;
  logic [BW-1:0]     blank_cnt;

  // Stage 1 carries the qualifier and markers while mem_rdata is in flight
  logic s1_valid, s1_sof, s1_eol, s1_eof;

  harris_raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .addr       (cnt_addr),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  assign mem_addr = cnt_addr;
  assign busy     = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and read issue; a start coinciding with done is dropped
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !done) begin
          state_next = ST_STREAM;
          cnt_clr    = 1'b1;
        end
      end
      ST_STREAM: begin
        if (!stall) begin
          mem_rd = 1'b1;
          cnt_en = 1'b1;
          if (last_pixel)                   state_next = ST_DRAIN;
          else if (last_col && (HBLANK > 0)) state_next = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (blank_cnt == BLANK_LAST) state_next = ST_STREAM;
      end
      ST_DRAIN: begin
        if (pixel_valid && eof) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Blank cycle counter, free of stall so the gap length is fixed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 blank_cnt <= '0;
    else if (state != ST_BLANK) blank_cnt <= '0;
    else                        blank_cnt <= blank_cnt + 1'b1;
  end

  // Stage 1: tag each issued read with its markers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= mem_rd;
      s1_sof   <= mem_rd && (cnt_addr == '0);
      s1_eol   <= mem_rd && last_col;
      s1_eof   <= mem_rd && last_pixel;
    end
  end

  // Stage 2: register the returned byte; pixel holds when nothing is valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
    end else begin
      pixel_valid <= s1_valid;
      sof         <= s1_sof;
      eol         <= s1_eol;
      eof         <= s1_eof;
      if (s1_valid) pixel <= mem_rdata;
    end
  end

  // Done pulses the cycle after the eof pixel, together with busy falling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == ST_DRAIN) && pixel_valid && eof;
  end

endmodule

// File: tb/tb_harris_pixel_source.sv
// tb/tb_harris_pixel_source.sv - scoreboard bench for harris_pixel_source
module tb_harris_pixel_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, a_start, b_start, stall;

  logic       a_mem_rd, b_mem_rd;
  logic [3:0] a_mem_addr, b_mem_addr;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] a_pixel, b_pixel;
  logic a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done;
  logic b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done;

  harris_pixel_source #(.IMG_W(4), .IMG_H(2), .ADDR_W(4), .HBLANK(0)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stall(stall),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .pixel(a_pixel), .pixel_valid(a_pixel_valid), .sof(a_sof), .eol(a_eol),
    .eof(a_eof), .busy(a_busy), .done(a_done)
  );

  harris_pixel_source #(.IMG_W(4), .IMG_H(2), .ADDR_W(4), .HBLANK(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stall(stall),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .pixel(b_pixel), .pixel_valid(b_pixel_valid), .sof(b_sof), .eol(b_eol),
    .eof(b_eof), .busy(b_busy), .done(b_done)
  );

  // Frame memory holds its own address; data returns one cycle after the read
  always @(posedge clk) begin
    a_rdata <= {4'd0, a_mem_addr};
    b_rdata <= {4'd0, b_mem_addr};
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [10:0] a_q[$], b_q[$];
  int a_vcyc[$], b_vcyc[$], a_dcyc[$], b_dcyc[$];
  logic [7:0] a_last = 8'd0, b_last = 8'd0;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // One cycle: sample outputs mid-cycle and score them against the expected queues
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      tests++;
      if (a_pixel_valid) begin
        a_vcyc.push_back(cyc);
        if (a_q.size() == 0) begin
          fails++; $display("FAIL a_extra_pixel got %h required none", a_pixel);
        end else begin
          e = a_q.pop_front();
          if ({a_eof, a_eol, a_sof, a_pixel} !== e) begin
            fails++; $display("FAIL a_pixel {eof,eol,sof,pix} got %h required %h", {a_eof, a_eol, a_sof, a_pixel}, e);
          end
        end
        a_last = a_pixel;
      end else if (a_pixel !== a_last) begin
        fails++; $display("FAIL a_hold got %h required %h", a_pixel, a_last);
      end
      tests++;
      if (b_pixel_valid) begin
        b_vcyc.push_back(cyc);
        if (b_q.size() == 0) begin
          fails++; $display("FAIL b_extra_pixel got %h required none", b_pixel);
        end else begin
          e = b_q.pop_front();
          if ({b_eof, b_eol, b_sof, b_pixel} !== e) begin
            fails++; $display("FAIL b_pixel {eof,eol,sof,pix} got %h required %h", {b_eof, b_eol, b_sof, b_pixel}, e);
          end
        end
        b_last = b_pixel;
      end else if (b_pixel !== b_last) begin
        fails++; $display("FAIL b_hold got %h required %h", b_pixel, b_last);
      end
      if (a_done) begin
        a_dcyc.push_back(cyc);
        tests++;
        if (a_busy !== 1'b0) begin fails++; $display("FAIL a_busy_at_done got %b required 0", a_busy); end
      end
      if (b_done) begin
        b_dcyc.push_back(cyc);
        tests++;
        if (b_busy !== 1'b0) begin fails++; $display("FAIL b_busy_at_done got %b required 0", b_busy); end
      end
    end
  endtask

  task automatic push_frame(input bit to_a, input bit to_b);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      p = 8'(i);
      if (to_a) a_q.push_back({(i == 7), (i % 4 == 3), (i == 0), p});
      if (to_b) b_q.push_back({(i == 7), (i % 4 == 3), (i == 0), p});
    end
  endtask

  task automatic pulse_start(input bit do_a, input bit do_b, output int s);
    a_start = do_a;
    b_start = do_b;
    s = cyc;
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; a_start = 1'b0; b_start = 1'b0; stall = 1'b0;
    tick(); tick();
    tests++;
    if ({a_mem_rd, a_mem_addr, a_pixel, a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done} !== '0) begin
      fails++; $display("FAIL a_reset_outputs got %h required 0",
        {a_mem_rd, a_mem_addr, a_pixel, a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done});
    end
    tests++;
    if ({b_mem_rd, b_mem_addr, b_pixel, b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done} !== '0) begin
      fails++; $display("FAIL b_reset_outputs got %h required 0",
        {b_mem_rd, b_mem_addr, b_pixel, b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    int s, ba, bb, da, db;
    ba = a_vcyc.size(); bb = b_vcyc.size(); da = a_dcyc.size(); db = b_dcyc.size();
    push_frame(1, 1);
    pulse_start(1, 1, s);
    tests++;
    if ({a_busy, b_busy} !== 2'b11) begin fails++; $display("FAIL frame_busy got %b required 11", {a_busy, b_busy}); end
    repeat (20) tick();
    tests++; if (a_vcyc.size() - ba != 8) begin fails++; $display("FAIL frame_a_count got %0d required 8", a_vcyc.size() - ba); end
    tests++; if (qat(a_vcyc, ba) != s + 3) begin fails++; $display("FAIL frame_a_first got %0d required %0d", qat(a_vcyc, ba), s + 3); end
    tests++; if (qat(a_vcyc, ba + 7) != s + 10) begin fails++; $display("FAIL frame_a_last got %0d required %0d", qat(a_vcyc, ba + 7), s + 10); end
    tests++; if (a_dcyc.size() - da != 1 || qat(a_dcyc, da) != s + 11) begin fails++; $display("FAIL frame_a_done got %0d required %0d", qat(a_dcyc, da), s + 11); end
    tests++; if (qat(b_vcyc, bb + 3) != s + 6) begin fails++; $display("FAIL blank_b_pix3 got %0d required %0d", qat(b_vcyc, bb + 3), s + 6); end
    tests++; if (qat(b_vcyc, bb + 4) != s + 9) begin fails++; $display("FAIL blank_b_pix4 got %0d required %0d", qat(b_vcyc, bb + 4), s + 9); end
    tests++; if (qat(b_vcyc, bb + 7) - qat(b_vcyc, bb) + 1 != 10) begin fails++; $display("FAIL blank_b_span got %0d required 10", qat(b_vcyc, bb + 7) - qat(b_vcyc, bb) + 1); end
    tests++; if (b_dcyc.size() - db != 1 || qat(b_dcyc, db) != s + 13) begin fails++; $display("FAIL blank_b_done got %0d required %0d", qat(b_dcyc, db), s + 13); end
    tests++; if (a_q.size() + b_q.size() != 0) begin fails++; $display("FAIL frame_missing got %0d required 0", a_q.size() + b_q.size()); end
  endtask

  task automatic test_stall();
    int s, ba, bb;
    ba = a_vcyc.size(); bb = b_vcyc.size();
    push_frame(1, 1);
    pulse_start(1, 1, s);
    tick(); tick();
    stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0;
    repeat (20) tick();
    tests++; if (qat(a_vcyc, ba + 1) != s + 4) begin fails++; $display("FAIL stall_a_pix1 got %0d required %0d", qat(a_vcyc, ba + 1), s + 4); end
    tests++; if (qat(a_vcyc, ba + 2) != s + 8) begin fails++; $display("FAIL stall_a_pix2 got %0d required %0d", qat(a_vcyc, ba + 2), s + 8); end
    tests++; if (qat(a_vcyc, ba + 7) != s + 13) begin fails++; $display("FAIL stall_a_pix7 got %0d required %0d", qat(a_vcyc, ba + 7), s + 13); end
    tests++; if (qat(b_vcyc, bb + 4) != s + 12) begin fails++; $display("FAIL stall_b_pix4 got %0d required %0d", qat(b_vcyc, bb + 4), s + 12); end
    tests++; if (qat(b_vcyc, bb + 7) != s + 15) begin fails++; $display("FAIL stall_b_pix7 got %0d required %0d", qat(b_vcyc, bb + 7), s + 15); end
    tests++; if (a_q.size() + b_q.size() != 0) begin fails++; $display("FAIL stall_missing got %0d required 0", a_q.size() + b_q.size()); end
  endtask

  task automatic test_start_while_busy();
    int s, s2, ba, bb, da, db;
    ba = a_vcyc.size(); bb = b_vcyc.size(); da = a_dcyc.size(); db = b_dcyc.size();
    push_frame(1, 1);
    pulse_start(1, 1, s);
    repeat (3) tick();
    pulse_start(1, 1, s2);
    repeat (25) tick();
    tests++; if (a_vcyc.size() - ba != 8 || b_vcyc.size() - bb != 8) begin fails++; $display("FAIL busy_start_count got %0d/%0d required 8/8", a_vcyc.size() - ba, b_vcyc.size() - bb); end
    tests++; if (a_dcyc.size() - da != 1 || b_dcyc.size() - db != 1) begin fails++; $display("FAIL busy_start_done got %0d/%0d required 1/1", a_dcyc.size() - da, b_dcyc.size() - db); end
  endtask

  task automatic test_reset_mid();
    int s, ba, da, db;
    push_frame(1, 1);
    ba = a_vcyc.size();
    pulse_start(1, 1, s);
    repeat (4) tick();
    tests++; if (qat(a_vcyc, ba + 2) != s + 5) begin fails++; $display("FAIL mid_pix2_time got %0d required %0d", qat(a_vcyc, ba + 2), s + 5); end
    reset = 1'b0;
    #1;
    tests++;
    if ({a_mem_rd, a_mem_addr, a_pixel, a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done,
         b_mem_rd, b_mem_addr, b_pixel, b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs got %h required 0",
        {a_mem_rd, a_mem_addr, a_pixel, a_pixel_valid, a_sof, a_eol, a_eof, a_busy, a_done,
         b_mem_rd, b_mem_addr, b_pixel, b_pixel_valid, b_sof, b_eol, b_eof, b_busy, b_done});
    end
    tick(); tick();
    a_q.delete(); b_q.delete();
    a_last = 8'd0; b_last = 8'd0;
    reset = 1'b1;
    da = a_dcyc.size(); db = b_dcyc.size();
    repeat (4) tick();
    tests++; if (a_dcyc.size() != da || b_dcyc.size() != db) begin fails++; $display("FAIL mid_abort_done got %0d required 0", a_dcyc.size() - da + b_dcyc.size() - db); end
    ba = a_vcyc.size();
    push_frame(1, 1);
    pulse_start(1, 1, s);
    repeat (20) tick();
    tests++; if (qat(a_vcyc, ba) != s + 3 || a_vcyc.size() - ba != 8) begin fails++; $display("FAIL mid_restart got first %0d count %0d required %0d/8", qat(a_vcyc, ba), a_vcyc.size() - ba, s + 3); end
    tests++; if (a_dcyc.size() - da != 1 || b_dcyc.size() - db != 1) begin fails++; $display("FAIL mid_restart_done got %0d/%0d required 1/1", a_dcyc.size() - da, b_dcyc.size() - db); end
  endtask

  task automatic test_back_to_back();
    int s, ba, bb, da;
    ba = a_vcyc.size(); bb = b_vcyc.size(); da = a_dcyc.size();
    push_frame(1, 0);
    push_frame(1, 0);
    pulse_start(1, 0, s);
    repeat (10) tick();
    // start held across the done cycle and the cycle after it
    a_start = 1'b1;
    tick(); tick();
    a_start = 1'b0;
    repeat (25) tick();
    tests++; if (qat(a_vcyc, ba + 7) != s + 10) begin fails++; $display("FAIL b2b_first_last got %0d required %0d", qat(a_vcyc, ba + 7), s + 10); end
    tests++; if (qat(a_vcyc, ba + 8) != s + 15) begin fails++; $display("FAIL b2b_second_first got %0d required %0d", qat(a_vcyc, ba + 8), s + 15); end
    tests++; if (a_vcyc.size() - ba != 16) begin fails++; $display("FAIL b2b_count got %0d required 16", a_vcyc.size() - ba); end
    tests++; if (a_dcyc.size() - da != 2 || qat(a_dcyc, da + 1) != s + 23) begin fails++; $display("FAIL b2b_done got %0d required %0d", qat(a_dcyc, da + 1), s + 23); end
    tests++; if (b_vcyc.size() != bb) begin fails++; $display("FAIL b2b_b_idle got %0d required 0", b_vcyc.size() - bb); end
    tests++; if (a_q.size() != 0) begin fails++; $display("FAIL b2b_missing got %0d required 0", a_q.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
